updown_cmd_gen: RTL
===================

Name: updown_cmd_gen

Overview:
- Upstream command stage for updown_counter.
- Turns three raw, bouncy push-button inputs (up, down, load) plus a 3-bit load value into clean, single-cycle command strobes on the counter's control inputs (ld_cnt, updn_cnt, count_enb, data_in).
- Adds synchronisation, per-button debounce, rising-edge detection, fixed-priority arbitration and optional auto-repeat for held up/down buttons.

Parameters:
- DB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (>=2).
- RPT_DELAY, 16, cycles a debounced up/down must stay high before auto-repeat starts; 0 disables auto-repeat.
- RPT_PERIOD, 8, cycles between auto-repeat pulses (>=2).
- DATA_W, 3, width of load value and data_in.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous reset, active-high
- btn_up  input  1  raw async button, 1 = pressed
- btn_dn  input  1  raw async button, 1 = pressed
- btn_ld  input  1  raw async button, 1 = pressed
- ld_value  input  DATA_W  value to load; sampled on load strobe cycle, quasi-static
- ld_cnt  output  1  1-cycle load strobe to counter
- updn_cnt  output  1  direction to counter, 1 = up, 0 = down; level, held
- count_enb  output  1  1-cycle count strobe to counter
- data_in  output  DATA_W  load data to counter, registered, held
- conflict  output  1  sticky: up and down edges arrived in the same cycle

Behaviour:
- Reset (rst=1 at a clk edge):
  - all sync flops, debounced levels, counters and edge registers cleared;
  - ld_cnt=0, count_enb=0, updn_cnt=1, data_in=0, conflict=0;
  - takes priority over every other event, including mid-debounce and mid-repeat; a button still pressed after reset must re-qualify from scratch.
- Sync: each btn_* passes through a 2-flop synchroniser.
- Debounce (per button):
  - counter increments while synced value != debounced level, clears when they match;
  - debounced level toggles on the cycle the counter reaches DB_CYCLES, then counter clears;
  - any glitch shorter than DB_CYCLES is ignored.
- Edge detect: press event = debounced rising edge, registered (1 cycle).
- Latency: a clean step on btn_* produces its strobe exactly DB_CYCLES+3 edges after the first edge that samples it high.
- Arbitration, evaluated on the same cycle as the events:
  - load event present: ld_cnt=1 for 1 cycle, data_in<=ld_value same edge; any simultaneous up/down event is dropped.
  - up only: count_enb=1 for 1 cycle, updn_cnt<=1 same edge.
  - down only: count_enb=1 for 1 cycle, updn_cnt<=0 same edge.
  - up and down together, no load: no strobe, updn_cnt unchanged, conflict<=1.
- ld_cnt and count_enb are never high in the same cycle.
- Auto-repeat (RPT_DELAY>0), FSM states IDLE, HOLD, REPEAT:
  - IDLE -> HOLD on an up or down press event; latch direction, clear timer.
  - HOLD: timer counts while the latched button stays debounced-high; at RPT_DELAY -> REPEAT, timer cleared, one strobe emitted.
  - REPEAT: one strobe every RPT_PERIOD cycles in the latched direction.
  - Any state -> IDLE when the latched button debounces low, or the opposite button or load press event occurs. The triggering event is then arbitrated normally.
  - Repeat strobes share the count_enb path and the same arbitration rules; load never repeats.
- conflict clears only on reset.
- Timer width: clog2(max(RPT_DELAY, RPT_PERIOD)+1); must not wrap.

Decomposition:
- Package updown_pkg:
  - DATA_W default;
  - FSM state enum (IDLE, HOLD, REPEAT);
  - direction constants DIR_UP=1, DIR_DN=0.
- Sub-module btn_debounce (synchroniser + debounce counter + registered rise pulse, parameter DB_CYCLES), instantiated three times.
- Arbitration and repeat FSM live in updown_cmd_gen.

Test Plan:
- Reset: assert rst with all buttons high -> ld_cnt=0, count_enb=0, updn_cnt=1, data_in=0, conflict=0; after release no strobe until DB_CYCLES+3 cycles pass.
- Clean up press: btn_up 0->1, held 10 cycles, DB_CYCLES=4, RPT_DELAY=0 -> exactly one count_enb pulse at cycle 7, updn_cnt=1; release -> no further pulse.
- Bounce: btn_dn toggles 1,0,1,0 on single cycles, then stable 1 -> glitches ignored; one count_enb at 7 cycles after stable-high start, updn_cnt=0.
- Load priority: ld_value=3'b101, btn_ld and btn_up rise on the same edge -> one ld_cnt pulse, data_in=5, no count_enb, updn_cnt unchanged.
- Conflict: btn_up and btn_dn rise together -> no strobes, conflict=1 and stays 1 until rst.
- Auto-repeat: RPT_DELAY=16, RPT_PERIOD=8, hold btn_up 60 cycles -> pulses at press+7, +23, +31, +39, ...; releasing btn_up (or pressing btn_ld) stops repeats within DB_CYCLES+3 cycles.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down command generator.
// Holds the repeat FSM state encoding and the direction encoding seen by the counter.
package updown_pkg;

  localparam int DATA_W_DEF = 3;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchroniser, stability counter and a
// registered single-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          prev_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive disagreement cycles; flip the level on the last one.
  always_comb begin
    level_d = level_q;
    cnt_d   = {CW{1'b0}};
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Synchroniser, debounce state and rise pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      rise_q  <= level_q & ~prev_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/updown_cmd_gen.sv
// Turns three raw buttons into clean load/count strobes for updown_counter,
// with fixed-priority arbitration and optional auto-repeat on held up/down.
module updown_cmd_gen
  import updown_pkg::*;
#(
  parameter int DB_CYCLES  = 4,
  parameter int RPT_DELAY  = 16,
  parameter int RPT_PERIOD = 8,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_dn,
  input  logic              btn_ld,
  input  logic [DATA_W-1:0] ld_value,
  output logic              ld_cnt,
  output logic              updn_cnt,
  output logic              count_enb,
  output logic [DATA_W-1:0] data_in,
  output logic              conflict
);

  localparam int TW = $clog2(max_int(RPT_DELAY, RPT_PERIOD) + 1);
  localparam logic [TW-1:0] DLY_LAST = TW'((RPT_DELAY > 0) ? RPT_DELAY - 1 : 0);
  localparam logic [TW-1:0] PER_LAST = TW'(RPT_PERIOD - 1);
  localparam logic RPT_EN = (RPT_DELAY > 0);

  logic up_lvl, up_rise;
  logic dn_lvl, dn_rise;
  logic ld_lvl, ld_rise;

  rpt_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q, dir_d;
  logic          rpt_ev;
  logic          lat_lvl;
  logic          opp_ev;
  logic          leave;

  logic              ld_q, ld_d;
  logic              enb_q, enb_d;
  logic              updn_q, updn_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              conflict_q, conflict_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_i(btn_up), .level_o(up_lvl), .rise_o(up_rise)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk(clk), .rst(rst), .btn_i(btn_dn), .level_o(dn_lvl), .rise_o(dn_rise)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ld (
    .clk(clk), .rst(rst), .btn_i(btn_ld), .level_o(ld_lvl), .rise_o(ld_rise)
  );

  // Repeat FSM next state; any competing press cancels the repeat.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    rpt_ev  = 1'b0;
    lat_lvl = (dir_q == DIR_UP) ? up_lvl : dn_lvl;
    opp_ev  = (dir_q == DIR_UP) ? dn_rise : up_rise;
    leave   = ~lat_lvl | opp_ev | ld_rise;
    case (state_q)
      IDLE: begin
        if (RPT_EN && !ld_rise && (up_rise ^ dn_rise)) begin
          state_d = HOLD;
          dir_d   = up_rise ? DIR_UP : DIR_DN;
          timer_d = {TW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (leave) begin
          state_d = IDLE;
          timer_d = {TW{1'b0}};
        end else if (timer_q == DLY_LAST) begin
          state_d = REPEAT;
          timer_d = {TW{1'b0}};
          rpt_ev  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      REPEAT: begin
        if (leave) begin
          state_d = IDLE;
          timer_d = {TW{1'b0}};
        end else if (timer_q == PER_LAST) begin
          timer_d = {TW{1'b0}};
          rpt_ev  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = {TW{1'b0}};
      end
    endcase
  end

  // Fixed priority: load, then up/down conflict, then single press, then repeat.
  always_comb begin
    ld_d       = 1'b0;
    enb_d      = 1'b0;
    updn_d     = updn_q;
    data_d     = data_q;
    conflict_d = conflict_q;
    if (ld_rise) begin
      ld_d   = 1'b1;
      data_d = ld_value;
    end else if (up_rise && dn_rise) begin
      conflict_d = 1'b1;
    end else if (up_rise) begin
      enb_d  = 1'b1;
      updn_d = DIR_UP;
    end else if (dn_rise) begin
      enb_d  = 1'b1;
      updn_d = DIR_DN;
    end else if (rpt_ev) begin
      enb_d  = 1'b1;
      updn_d = dir_q;
    end else begin
      enb_d = 1'b0;
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= {TW{1'b0}};
      dir_q      <= DIR_UP;
      ld_q       <= 1'b0;
      enb_q      <= 1'b0;
      updn_q     <= DIR_UP;
      data_q     <= {DATA_W{1'b0}};
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      dir_q      <= dir_d;
      ld_q       <= ld_d;
      enb_q      <= enb_d;
      updn_q     <= updn_d;
      data_q     <= data_d;
      conflict_q <= conflict_d;
    end
  end

  assign ld_cnt    = ld_q;
  assign count_enb = enb_q;
  assign updn_cnt  = updn_q;
  assign data_in   = data_q;
  assign conflict  = conflict_q;

endmodule
